// File: rtl/wb_i2c_arbiter.sv
// Two-requester Wishbone arbiter in front of a wbi2cmaster port. Grants are held for whole
// cycles, and ownership is locked from an I2C start command until the owner reads not-busy.
module wb_i2c_arbiter #(
  parameter int unsigned ADDR_W       = 6,
  parameter logic [23:0] LOCK_TIMEOUT = 24'd10000000
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_s0_cyc,
  input  logic              i_s1_cyc,
  input  logic              i_s0_stb,
  input  logic              i_s1_stb,
  input  logic              i_s0_we,
  input  logic              i_s1_we,
  input  logic [ADDR_W-1:0] i_s0_addr,
  input  logic [ADDR_W-1:0] i_s1_addr,
  input  logic [31:0]       i_s0_data,
  input  logic [31:0]       i_s1_data,
  input  logic [3:0]        i_s0_sel,
  input  logic [3:0]        i_s1_sel,
  output logic              o_s0_stall,
  output logic              o_s1_stall,
  output logic              o_s0_ack,
  output logic              o_s1_ack,
  output logic [31:0]       o_s0_data,
  output logic [31:0]       o_s1_data,
  output logic              o_m_cyc,
  output logic              o_m_stb,
  output logic              o_m_we,
  output logic [ADDR_W-1:0] o_m_addr,
  output logic [31:0]       o_m_data,
  output logic [3:0]        o_m_sel,
  input  logic              i_m_stall,
  input  logic              i_m_ack,
  input  logic [31:0]       i_m_data,
  output logic              o_owner,
  output logic              o_locked,
  output logic              o_timeout
);

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_LOCKED} state_t;

  state_t      state_q, state_d;
  logic        owner_q, owner_d;
  logic        last_owner_q, last_owner_d;
  logic        pending_q, pending_d;
  logic        rd_stat_q, rd_stat_d;
  logic        timeout_q, timeout_d;
  logic [23:0] cnt_q, cnt_d;

  logic              req0, req1, granted, locked;
  logic              own_cyc, own_stb, own_we;
  logic [ADDR_W-1:0] own_addr;
  logic [31:0]       own_data;
  logic [3:0]        own_sel;
  logic              m_stb, accept, is_cmd, lock_set, lock_clr, tmo_hit;

  assign req0    = i_s0_cyc & i_s0_stb;
  assign req1    = i_s1_cyc & i_s1_stb;
  assign granted = (state_q != S_IDLE);
  assign locked  = (state_q == S_LOCKED);

  always_comb begin
    if (owner_q) begin
      own_cyc = i_s1_cyc; own_stb = i_s1_stb; own_we = i_s1_we;
      own_addr = i_s1_addr; own_data = i_s1_data; own_sel = i_s1_sel;
    end else begin
      own_cyc = i_s0_cyc; own_stb = i_s0_stb; own_we = i_s0_we;
      own_addr = i_s0_addr; own_data = i_s0_data; own_sel = i_s0_sel;
    end
  end

  assign m_stb  = granted & own_stb & ~pending_q;
  assign accept = m_stb & ~i_m_stall;
  // Register 0 is the command register on write and the status register on read.
  assign is_cmd   = ~own_addr[ADDR_W-1] & (own_addr[1:0] == 2'b00);
  assign lock_set = accept & own_we & is_cmd & (|own_data[ADDR_W:0]);
  assign lock_clr = pending_q & i_m_ack & rd_stat_q & ~i_m_data[31];
  assign tmo_hit  = locked & (cnt_q == LOCK_TIMEOUT - 24'd1);

  // State register
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q      <= S_IDLE;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
      pending_q    <= 1'b0;
      rd_stat_q    <= 1'b0;
      timeout_q    <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      pending_q    <= pending_d;
      rd_stat_q    <= rd_stat_d;
      timeout_q    <= timeout_d;
      cnt_q        <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    case (state_q)
      S_IDLE: begin
        if (req0 | req1) begin
          state_d = S_GRANT;
          owner_d = (req0 & req1) ? ~last_owner_q : req1;
        end
      end
      S_GRANT: begin
        if (lock_set) begin
          state_d = S_LOCKED;
        end else if (~own_cyc & ~pending_q) begin
          state_d      = S_IDLE;
          last_owner_d = owner_q;
        end
      end
      S_LOCKED: begin
        // A new start command restarts the lock window even on the timeout cycle.
        if (lock_clr)      state_d = S_GRANT;
        else if (lock_set) state_d = S_LOCKED;
        else if (tmo_hit)  state_d = S_GRANT;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    pending_d = pending_q;
    if (pending_q & i_m_ack) pending_d = 1'b0;
    if (accept)              pending_d = 1'b1;
    rd_stat_d = accept ? (~own_we & is_cmd) : rd_stat_q;
    timeout_d = tmo_hit & ~lock_clr & ~lock_set;
    cnt_d     = (locked & ~lock_set & ~lock_clr & ~tmo_hit) ? cnt_q + 24'd1 : 24'd0;
  end

  // Outputs
  always_comb begin
    o_m_cyc    = granted & (own_cyc | pending_q);
    o_m_stb    = m_stb;
    o_m_we     = granted & own_we;
    o_m_addr   = granted ? own_addr : '0;
    o_m_data   = granted ? own_data : '0;
    o_m_sel    = granted ? own_sel : '0;
    o_s0_stall = ~(granted & ~owner_q) | pending_q | i_m_stall;
    o_s1_stall = ~(granted & owner_q) | pending_q | i_m_stall;
    // Only an ack for our own accepted request reaches a requester still in its cycle.
    o_s0_ack   = granted & pending_q & i_m_ack & ~owner_q & i_s0_cyc;
    o_s1_ack   = granted & pending_q & i_m_ack & owner_q & i_s1_cyc;
  end

  assign o_s0_data = i_m_data;
  assign o_s1_data = i_m_data;
  assign o_owner   = owner_q;
  assign o_locked  = locked;
  assign o_timeout = timeout_q;

endmodule

// File: tb/tb_wb_i2c_arbiter.sv
// Bench for wb_i2c_arbiter: vector table of single transfers plus hand-written sequences
// for round-robin, lock hold, timeout and reset; a slave model feeds a response scoreboard.
module tb_wb_i2c_arbiter;
  localparam int          AW = 6;
  localparam logic [23:0] LT = 24'd100;

  logic          i_clk = 1'b0;
  logic          i_reset = 1'b1;
  logic          cyc [2];
  logic          stb [2];
  logic          we  [2];
  logic [AW-1:0] addr[2];
  logic [31:0]   wdat[2];
  logic [3:0]    sel [2];
  logic          o_s0_stall, o_s1_stall, o_s0_ack, o_s1_ack;
  logic [31:0]   o_s0_data, o_s1_data;
  logic          o_m_cyc, o_m_stb, o_m_we;
  logic [AW-1:0] o_m_addr;
  logic [31:0]   o_m_data;
  logic [3:0]    o_m_sel;
  logic          m_stall = 1'b0;
  logic          m_ack = 1'b0, man_ack = 1'b0;
  logic [31:0]   m_rdata = 32'h0, man_rdata = 32'h0;
  logic          o_owner, o_locked, o_timeout;
  bit            slave_en = 1'b1;

  int checks = 0;
  int errors = 0;

  typedef struct { bit p; bit we; logic [AW-1:0] a; logic [31:0] d; logic [31:0] rsp; } req_t;
  typedef struct { bit p; bit we; logic [AW-1:0] a; logic [31:0] d; logic [31:0] rsp; int stl; bit lk; } vec_t;
  req_t req_q[$];
  req_t ack_q[$];
  vec_t vec[12];

  wb_i2c_arbiter #(.ADDR_W(AW), .LOCK_TIMEOUT(LT)) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_s0_cyc(cyc[0]), .i_s1_cyc(cyc[1]), .i_s0_stb(stb[0]), .i_s1_stb(stb[1]),
    .i_s0_we(we[0]), .i_s1_we(we[1]), .i_s0_addr(addr[0]), .i_s1_addr(addr[1]),
    .i_s0_data(wdat[0]), .i_s1_data(wdat[1]), .i_s0_sel(sel[0]), .i_s1_sel(sel[1]),
    .o_s0_stall(o_s0_stall), .o_s1_stall(o_s1_stall), .o_s0_ack(o_s0_ack), .o_s1_ack(o_s1_ack),
    .o_s0_data(o_s0_data), .o_s1_data(o_s1_data),
    .o_m_cyc(o_m_cyc), .o_m_stb(o_m_stb), .o_m_we(o_m_we), .o_m_addr(o_m_addr),
    .o_m_data(o_m_data), .o_m_sel(o_m_sel),
    .i_m_stall(m_stall), .i_m_ack(m_ack | man_ack), .i_m_data(m_rdata | man_rdata),
    .o_owner(o_owner), .o_locked(o_locked), .o_timeout(o_timeout)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, want);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0b, expected %0b", name, act, want);
    end
  endtask

  function automatic logic stall_of(input bit p);
    return p ? o_s1_stall : o_s0_stall;
  endfunction
  function automatic logic ack_of(input bit p);
    return p ? o_s1_ack : o_s0_ack;
  endfunction
  function automatic logic [31:0] data_of(input bit p);
    return p ? o_s1_data : o_s0_data;
  endfunction

  task automatic drive(input bit p, input bit c, input bit s, input bit w,
                       input logic [AW-1:0] a, input logic [31:0] d);
    cyc[p] = c; stb[p] = s; we[p] = w; addr[p] = a; wdat[p] = d;
  endtask

  // One single-beat transfer; nst returns the number of stalled cycles before acceptance.
  task automatic wb_xfer(input bit p, input bit w, input logic [AW-1:0] a, input logic [31:0] d,
                         input logic [31:0] rsp, input int max_wait, output int nst);
    bit ok;
    req_t r;
    nst = 0;
    @(posedge i_clk); #1;
    drive(p, 1'b1, 1'b1, w, a, d);
    ok = 1'b0;
    for (int i = 0; i < max_wait; i++) begin
      @(negedge i_clk);
      if (!stall_of(p)) begin ok = 1'b1; break; end
      nst++;
    end
    if (!ok) begin
      chk1($sformatf("s%0d_accept_wait", p), stall_of(p), 1'b0);
      drive(p, 1'b0, 1'b0, 1'b0, '0, '0);
      return;
    end
    r = '{p: p, we: w, a: a, d: d, rsp: rsp};
    req_q.push_back(r);
    @(posedge i_clk); #1;
    stb[p] = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge i_clk);
      if (ack_of(p)) begin ok = 1'b1; break; end
    end
    if (!ok) chk1($sformatf("s%0d_ack_wait", p), ack_of(p), 1'b1);
    @(posedge i_clk); #1;
    drive(p, 1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  // Slave model: checks the muxed request against the scoreboard, acks one cycle later.
  always begin : slave
    req_t r;
    bit fire;
    logic [31:0] rd;
    @(negedge i_clk); #1;
    fire = 1'b0;
    rd = 32'h0;
    if (slave_en && !i_reset && o_m_stb && !m_stall) begin
      if (req_q.size() == 0) begin
        chk1("unexpected_m_stb", o_m_stb, 1'b0);
      end else begin
        r = req_q.pop_front();
        chk1("m_we", o_m_we, r.we);
        chk("m_addr", 32'(o_m_addr), 32'(r.a));
        chk("m_sel", 32'(o_m_sel), r.p ? 32'h3 : 32'hF);
        if (r.we) chk("m_data", o_m_data, r.d);
        fire = 1'b1;
        rd = r.rsp;
        ack_q.push_back(r);
      end
    end
    @(posedge i_clk); #1;
    m_ack = fire;
    m_rdata = fire ? rd : 32'h0;
  end

  always begin : ack_mon
    req_t r;
    @(negedge i_clk); #2;
    for (int p = 0; p < 2; p++) begin
      if (ack_of(p[0])) begin
        if (ack_q.size() == 0) begin
          chk1($sformatf("s%0d_stray_ack", p), ack_of(p[0]), 1'b0);
        end else begin
          r = ack_q.pop_front();
          chk1("ack_port", p[0], r.p);
          chk($sformatf("s%0d_ack_data", p), data_of(p[0]), r.rsp);
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int n0, n1, tcyc;
    bit s0_rel;
    for (int p = 0; p < 2; p++) drive(p[0], 1'b0, 1'b0, 1'b0, '0, '0);
    sel[0] = 4'hF;
    sel[1] = 4'h3;

    //          p     we    addr   wdata         rsp           stl lk
    vec[0]  = '{1'b0, 1'b0, 6'h01, 32'h0,        32'h000003E8, 1, 1'b0};
    vec[1]  = '{1'b1, 1'b0, 6'h02, 32'h0,        32'h12345678, 1, 1'b0};
    vec[2]  = '{1'b0, 1'b1, 6'h00, 32'h00A20000, 32'h0,        1, 1'b0};
    vec[3]  = '{1'b0, 1'b1, 6'h00, 32'h00000080, 32'h0,        1, 1'b0};
    vec[4]  = '{1'b1, 1'b1, 6'h20, 32'h000000FF, 32'h0,        1, 1'b0};
    vec[5]  = '{1'b1, 1'b1, 6'h01, 32'h000000FF, 32'h0,        1, 1'b0};
    vec[6]  = '{1'b0, 1'b1, 6'h00, 32'h00A20004, 32'h0,        1, 1'b1};
    vec[7]  = '{1'b0, 1'b0, 6'h00, 32'h0,        32'h80000000, 0, 1'b1};
    vec[8]  = '{1'b0, 1'b0, 6'h00, 32'h0,        32'h00000000, 0, 1'b0};
    vec[9]  = '{1'b1, 1'b1, 6'h00, 32'h00000001, 32'h0,        1, 1'b1};
    vec[10] = '{1'b1, 1'b0, 6'h20, 32'h0,        32'h00000000, 0, 1'b1};
    vec[11] = '{1'b1, 1'b0, 6'h00, 32'h0,        32'h00000000, 0, 1'b0};

    // Reset state
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    chk1("rst_s0_stall", o_s0_stall, 1'b1);
    chk1("rst_s1_stall", o_s1_stall, 1'b1);
    chk1("rst_m_cyc", o_m_cyc, 1'b0);
    chk1("rst_m_stb", o_m_stb, 1'b0);
    chk1("rst_locked", o_locked, 1'b0);
    chk1("rst_owner", o_owner, 1'b0);
    chk1("rst_timeout", o_timeout, 1'b0);
    chk1("rst_s0_ack", o_s0_ack, 1'b0);
    @(posedge i_clk); #1;
    i_reset = 1'b0;

    // Vector table
    for (int i = 0; i < 12; i++) begin
      wb_xfer(vec[i].p, vec[i].we, vec[i].a, vec[i].d, vec[i].rsp, 50, n0);
      chk($sformatf("v%0d_stall", i), n0, vec[i].stl);
      @(negedge i_clk);
      chk1($sformatf("v%0d_locked", i), o_locked, vec[i].lk);
      chk1($sformatf("v%0d_owner", i), o_owner, vec[i].p);
    end

    // Round-robin: from reset s0 wins, after an s0 cycle s1 wins
    @(posedge i_clk); #1; i_reset = 1'b1;
    @(posedge i_clk); #1; i_reset = 1'b0;
    fork
      wb_xfer(1'b0, 1'b0, 6'h01, 32'h0, 32'h00000011, 60, n0);
      wb_xfer(1'b1, 1'b0, 6'h02, 32'h0, 32'h00000022, 60, n1);
    join
    chk("rr1_s0_stall", n0, 32'd1);
    chk("rr1_s1_stall", n1, 32'd5);
    wb_xfer(1'b0, 1'b0, 6'h03, 32'h0, 32'h00000033, 50, n0);
    fork
      wb_xfer(1'b0, 1'b0, 6'h01, 32'h0, 32'h00000044, 60, n0);
      wb_xfer(1'b1, 1'b0, 6'h02, 32'h0, 32'h00000055, 60, n1);
    join
    chk("rr2_s0_stall", n0, 32'd5);
    chk("rr2_s1_stall", n1, 32'd1);

    // Lock holds the grant while the owner is idle; s1 waits for the not-busy status read
    wb_xfer(1'b0, 1'b1, 6'h00, 32'h00A20004, 32'h0, 50, n0);
    s0_rel = 1'b0;
    fork
      begin
        wb_xfer(1'b1, 1'b0, 6'h03, 32'h0, 32'h00000066, 80, n1);
        chk1("s1_after_unlock", s0_rel, 1'b1);
      end
      begin
        repeat (3) @(negedge i_clk);
        chk1("lk_locked", o_locked, 1'b1);
        chk1("lk_s1_stall", o_s1_stall, 1'b1);
        chk1("lk_m_cyc_idle", o_m_cyc, 1'b0);
        chk1("lk_owner", o_owner, 1'b0);
        wb_xfer(1'b0, 1'b0, 6'h00, 32'h0, 32'h80000000, 50, n0);
        chk1("lk_busy_read", o_locked, 1'b1);
        wb_xfer(1'b0, 1'b0, 6'h00, 32'h0, 32'h00000000, 50, n0);
        chk1("lk_idle_read", o_locked, 1'b0);
        s0_rel = 1'b1;
      end
    join
    @(negedge i_clk);
    chk1("lk_owner_s1", o_owner, 1'b1);

    // Timeout: pulse 100 cycles after the lock-set edge, then s1 is granted
    wb_xfer(1'b0, 1'b1, 6'h00, 32'h00000003, 32'h0, 50, n0);
    fork
      wb_xfer(1'b1, 1'b0, 6'h01, 32'h0, 32'h00000077, 150, n1);
      begin
        tcyc = -1;
        for (int c = 1; c < 200; c++) begin
          @(negedge i_clk);
          if (o_timeout) begin tcyc = c; break; end
        end
        chk("tmo_cycle", tcyc, 32'd100);
        chk1("tmo_unlocked", o_locked, 1'b0);
        @(negedge i_clk);
        chk1("tmo_pulse_width", o_timeout, 1'b0);
      end
    join
    chk("tmo_s1_stall", n1, 32'd100);
    @(negedge i_clk);
    chk1("tmo_owner_s1", o_owner, 1'b1);

    // Reset while locked with a read pending; the late ack must be swallowed
    wb_xfer(1'b0, 1'b1, 6'h00, 32'h00A20004, 32'h0, 50, n0);
    slave_en = 1'b0;
    @(posedge i_clk); #1;
    drive(1'b0, 1'b1, 1'b1, 1'b0, 6'h00, 32'h0);
    @(negedge i_clk);
    chk1("rr_locked_grant", o_s0_stall, 1'b0);
    @(posedge i_clk); #1;
    stb[0] = 1'b0;
    i_reset = 1'b1;
    @(negedge i_clk);
    chk1("rr_pending_cyc", o_m_cyc, 1'b1);
    @(posedge i_clk); #1;
    i_reset = 1'b0;
    man_ack = 1'b1;
    @(negedge i_clk);
    chk1("rr_locked", o_locked, 1'b0);
    chk1("rr_m_cyc", o_m_cyc, 1'b0);
    chk1("rr_s0_stall", o_s0_stall, 1'b1);
    chk1("rr_s1_stall", o_s1_stall, 1'b1);
    chk1("rr_s0_ack", o_s0_ack, 1'b0);
    chk1("rr_s1_ack", o_s1_ack, 1'b0);
    @(posedge i_clk); #1;
    man_ack = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    slave_en = 1'b1;
    req_q.delete();
    ack_q.delete();
    repeat (3) @(posedge i_clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/wb_i2c_arbiter.md
Name: wb_i2c_arbiter

Overview:
- Two-requester Wishbone arbiter that shares one wbi2cmaster register/buffer port between two bus masters, e.g. CPU and a sensor-polling DMA.
- Grants are held for whole Wishbone cycles.
- Ownership is locked from an I2C command write until the owner observes not-busy in a status read, or a timeout fires.
- This keeps a second master from rewriting the command, speed or buffer registers during an owned I2C transfer.

Parameters:
- ADDR_W, 6: word-address width, equal to the I2C master's MEM_ADDR_BITS-1. addr[ADDR_W-1]=1 selects the buffer; addr[1:0] selects the register otherwise.
- LOCK_TIMEOUT, 24'd10000000: cycles a lock may persist before forced release. Nonzero.

Ports:
- i_clk  in  1  clock
- i_reset  in  1  synchronous active-high reset
- i_s0_cyc, i_s1_cyc  in  1  requester cycle
- i_s0_stb, i_s1_stb  in  1  requester strobe
- i_s0_we, i_s1_we  in  1  write enable
- i_s0_addr, i_s1_addr  in  ADDR_W  word address
- i_s0_data, i_s1_data  in  32  write data
- i_s0_sel, i_s1_sel  in  4  byte selects
- o_s0_stall, o_s1_stall  out  1  stall to requester
- o_s0_ack, o_s1_ack  out  1  ack to requester
- o_s0_data, o_s1_data  out  32  read data: i_m_data, unregistered
- o_m_cyc, o_m_stb, o_m_we  out  1  to I2C master
- o_m_addr  out  ADDR_W
- o_m_data  out  32
- o_m_sel  out  4
- i_m_stall, i_m_ack  in  1
- i_m_data  in  32
- o_owner  out  1  current/last owner index
- o_locked  out  1  lock active
- o_timeout  out  1  one-cycle pulse on forced release

Behaviour:
- Reset: granted=0, owner=0, last_owner=1, locked=0, pending=0, counter=0. All outputs are low, except o_sN_stall, which is 1 while not granted.
- Clock and reset: i_clk; i_reset, synchronous, active-high. Reset mid-transfer drops the grant immediately, and any in-flight ack is discarded.
- States:
  - IDLE (granted=0).
  - GRANT (granted=1, not locked).
  - LOCKED (granted=1, locked=1).
- IDLE arbitration:
  - Requester N requests when cyc&stb.
  - Single request: grant to it on the next edge.
  - Both requesting: grant to !last_owner (round-robin).
  - Arbitration costs 1 cycle; the requester is stalled during that cycle.
- Master mux:
  - o_m_cyc = granted & (owner cyc | pending).
  - o_m_stb = granted & owner stb & !pending.
  - we/addr/data/sel come from the owner.
  - Owner stall = !granted | pending | i_m_stall. Non-owner stall = 1; non-owner ack = 0.
- Single outstanding request: pending sets when o_m_stb & !i_m_stall, and clears on i_m_ack.
  - o_sN_ack = i_m_ack & owner==N & owner cyc.
  - An ack arriving after the owner drops cyc is swallowed.
- Lock set: an accepted owner write with addr[ADDR_W-1]=0, addr[1:0]=00 and data[ADDR_W:0]!=0. This is the I2C start command.
  - Counter loads 0.
  - Writes with count 0 do not lock.
- Lock clear: an ack for an accepted owner read of status (addr[ADDR_W-1]=0, addr[1:0]=00) with i_m_data[31]=0.
  - The status/read flag is captured at acceptance.
  - The clear is evaluated even if the ack is swallowed.
- Timeout:
  - The counter increments each locked cycle. Owner activity does not reload it.
  - At LOCK_TIMEOUT-1: locked<=0, o_timeout=1 for 1 cycle, counter<=0.
  - Lock clear and timeout in the same cycle: clear wins, and no pulse is generated.
- Release:
  - Allowed when owner cyc=0 & pending=0 & !locked. Then granted<=0 and last_owner<=owner.
  - In LOCKED with owner cyc low, the grant is held and the other requester stays stalled.
  - Once in IDLE, the next grant is available the following cycle.
- Simultaneous:
  - Lock-set write accepted in the same cycle the owner drops cyc: the lock wins and the grant is held.
  - Timeout while a request is pending: release waits for pending=0.

Test Plan:
- s0 single read of addr 1, slave acks next cycle with 0x000003E8 -> arbitration stall 1 cycle, then o_m_stb for 1 cycle, o_s0_ack with data 0x3E8, o_owner=0, release 1 cycle after s0 cyc drops.
- s0 and s1 raise cyc&stb together from reset -> s0 granted first (last_owner=1), s1 stalled throughout; after s0 releases, s1 is granted within 2 cycles.
- s0 writes addr 0 data 0x00A20004, then drops cyc; s1 requests -> o_locked=1 and s1 stays stalled. s0 reads status and gets 0x80000000 -> still locked. s0 reads status again and gets 0x00000000 -> unlocked, s1 granted.
- s0 writes addr 0 data 0x00A20000 (count 0) -> o_locked stays 0.
- LOCK_TIMEOUT=100, s0 locks then idles, s1 requesting -> o_timeout pulses exactly 100 cycles after lock set, s1 granted afterwards.
- s0 lock set, i_reset asserted mid-lock with a read pending -> next cycle o_locked=0, o_m_cyc=0, both stalls=1, late i_m_ack produces no o_sN_ack.
